fetch_decode_buffer: RTL and testbench

//   Fetch-to-decode pipeline buffer: captures each fetched instruction with its PC+2 and halt flag,
//   and presents them to the decode stage over a valid/ready handshake.

---
 rtl/fetch_decode_buffer.sv | 134 +++++++++++++
 tb/tb_fetch_decode_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode skid buffer: a small circular queue of {inst, pc_inc, createdump}
// entries with a valid/ready handshake on both sides and a flush for redirects.
module fetch_decode_buffer #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_valid,
    output logic                     f_ready,
    input  logic [15:0]              f_inst,
    input  logic [15:0]              f_pc_inc,
    input  logic                     f_createdump,
    input  logic                     flush,
    output logic                     d_valid,
    input  logic                     d_ready,
    output logic [15:0]              d_inst,
    output logic [15:0]              d_pc_inc,
    output logic                     d_createdump,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_LAST = OW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   occ_reg, occ_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;

    logic [15:0]     inst_mem [DEPTH];
    logic [15:0]     pc_mem   [DEPTH];
    logic            dump_mem [DEPTH];

    logic            push;
    logic            pop;

    // Handshake flags come only from registered state, so fetch never sees d_ready.
    assign f_ready = (state_reg != ST_FULL);
    assign d_valid = (state_reg != ST_EMPTY);
    assign push    = f_valid & f_ready & ~flush;
    assign pop     = d_valid & d_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_EMPTY;
            occ_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            occ_reg    <= occ_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        occ_next    = occ_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        case (state_reg)
            ST_EMPTY: begin
                if (push) begin
                    occ_next   = OW'(1);
                    state_next = (OCC_FULL == OW'(1)) ? ST_FULL : ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (push && !pop) begin
                    occ_next   = occ_reg + 1'b1;
                    state_next = (occ_reg == OCC_LAST) ? ST_FULL : ST_PARTIAL;
                end else if (pop && !push) begin
                    occ_next   = occ_reg - 1'b1;
                    state_next = (occ_reg == OW'(1)) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    occ_next   = OCC_LAST;
                    state_next = (OCC_LAST == '0) ? ST_EMPTY : ST_PARTIAL;
                end
            end
            default: begin
                state_next = ST_EMPTY;
                occ_next   = '0;
            end
        endcase

        // A redirect wins over everything, including the push/pop decoded above.
        if (flush) begin
            state_next  = ST_EMPTY;
            occ_next    = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end
    end

    // Storage carries no reset; validity is tracked entirely by occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    inst_mem[gi] <= f_inst;
                    pc_mem[gi]   <= f_pc_inc;
                    dump_mem[gi] <= f_createdump;
                end
            end
        end
    endgenerate

    assign d_inst       = d_valid ? inst_mem[rd_ptr_reg] : NOP_INST;
    assign d_pc_inc     = d_valid ? pc_mem[rd_ptr_reg]   : 16'h0000;
    assign d_createdump = d_valid ? dump_mem[rd_ptr_reg] : 1'b0;
    assign occupancy    = occ_reg;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed and randomized checks of fetch_decode_buffer (DEPTH=2) against
// hand-computed values and a queue model.
module tb_fetch_decode_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic        f_ready;
    logic [15:0] f_inst;
    logic [15:0] f_pc_inc;
    logic        f_createdump;
    logic        flush;
    logic        d_valid;
    logic        d_ready;
    logic [15:0] d_inst;
    logic [15:0] d_pc_inc;
    logic        d_createdump;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode_buffer #(.DEPTH(2), .NOP_INST(16'h0800)) dut (
        .clk          (clk),
        .rst          (rst),
        .f_valid      (f_valid),
        .f_ready      (f_ready),
        .f_inst       (f_inst),
        .f_pc_inc     (f_pc_inc),
        .f_createdump (f_createdump),
        .flush        (flush),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_inst       (d_inst),
        .d_pc_inc     (d_pc_inc),
        .d_createdump (d_createdump),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc, input logic dump);
        f_valid      = v;
        f_inst       = inst;
        f_pc_inc     = pc;
        f_createdump = dump;
    endtask

    logic [32:0] model_q[$];
    logic        m_push, m_pop;
    logic [32:0] head;

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        d_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);

        // Reset
        tick();
        tick();
        check("rst_d_valid", {31'b0, d_valid}, 32'd0);
        check("rst_f_ready", {31'b0, f_ready}, 32'd1);
        check("rst_d_inst", {16'b0, d_inst}, 32'h0800);
        check("rst_occ", {30'b0, occupancy}, 32'd0);
        check("rst_d_pc", {16'b0, d_pc_inc}, 32'd0);
        rst = 1'b1;
        tick();
        $display("txn reset: d_inst=%h occ=%0d", d_inst, occupancy);

        // Streaming with d_ready held high
        d_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 16'(k * 16'h1111), 16'(2 * k), 1'b0);
            tick();
            check("stream_inst", {16'b0, d_inst}, 32'(k * 16'h1111));
            check("stream_pc", {16'b0, d_pc_inc}, 32'(2 * k));
            check("stream_occ", {30'b0, occupancy}, 32'd1);
            $display("txn stream %0d: d_inst=%h d_pc_inc=%h", k, d_inst, d_pc_inc);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        check("stream_drain", {30'b0, occupancy}, 32'd0);

        // Stall
        d_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 16'h0010, 1'b0);
        tick();
        check("stall_a_inst", {16'b0, d_inst}, 32'hAAAA);
        drive(1'b1, 16'hBBBB, 16'h0012, 1'b0);
        tick();
        check("stall_full_ready", {31'b0, f_ready}, 32'd0);
        check("stall_occ2", {30'b0, occupancy}, 32'd2);
        drive(1'b1, 16'hCCCC, 16'h0014, 1'b0);
        tick();
        check("stall_hold_inst", {16'b0, d_inst}, 32'hAAAA);
        check("stall_no_c", {30'b0, occupancy}, 32'd2);
        $display("txn stall: d_inst=%h occ=%0d f_ready=%b", d_inst, occupancy, f_ready);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        d_ready = 1'b1;
        tick();
        check("release_b", {16'b0, d_inst}, 32'hBBBB);
        check("release_ready", {31'b0, f_ready}, 32'd1);
        tick();
        check("release_empty", {16'b0, d_inst}, 32'h0800);
        check("release_occ0", {30'b0, occupancy}, 32'd0);

        // Full with simultaneous pop
        d_ready = 1'b0;
        drive(1'b1, 16'h3333, 16'h0020, 1'b0);
        tick();
        drive(1'b1, 16'h4444, 16'h0022, 1'b0);
        tick();
        d_ready = 1'b1;
        drive(1'b1, 16'hDDDD, 16'h0024, 1'b0);
        check("fullpop_ready", {31'b0, f_ready}, 32'd0);
        tick();
        check("fullpop_inst", {16'b0, d_inst}, 32'h4444);
        check("fullpop_occ", {30'b0, occupancy}, 32'd1);
        tick();
        check("fullpop_d", {16'b0, d_inst}, 32'hDDDD);
        check("fullpop_d_pc", {16'b0, d_pc_inc}, 32'h0024);
        $display("txn fullpop: d_inst=%h occ=%0d", d_inst, occupancy);
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        tick();

        // Flush with two entries held and a push attempt
        d_ready = 1'b0;
        drive(1'b1, 16'h5555, 16'h0030, 1'b0);
        tick();
        drive(1'b1, 16'h6666, 16'h0032, 1'b0);
        tick();
        drive(1'b1, 16'hEEEE, 16'h0034, 1'b0);
        flush = 1'b1;
        d_ready = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("flush_occ", {30'b0, occupancy}, 32'd0);
        check("flush_valid", {31'b0, d_valid}, 32'd0);
        check("flush_inst", {16'b0, d_inst}, 32'h0800);
        tick();
        check("flush_no_e", {31'b0, d_valid}, 32'd0);
        // Flush while partial cancels an otherwise-legal push
        d_ready = 1'b0;
        drive(1'b1, 16'h7777, 16'h0040, 1'b0);
        tick();
        drive(1'b1, 16'h8888, 16'h0042, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("flush_partial_occ", {30'b0, occupancy}, 32'd0);
        $display("txn flush: d_valid=%b occ=%0d", d_valid, occupancy);

        // Halt flag and asynchronous reset
        drive(1'b1, 16'h0000, 16'h1234, 1'b1);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("halt_dump", {31'b0, d_createdump}, 32'd1);
        check("halt_pc", {16'b0, d_pc_inc}, 32'h1234);
        check("halt_inst", {16'b0, d_inst}, 32'h0000);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", {31'b0, d_valid}, 32'd0);
        check("async_occ", {30'b0, occupancy}, 32'd0);
        check("async_dump", {31'b0, d_createdump}, 32'd0);
        $display("txn async reset: d_valid=%b occ=%0d", d_valid, occupancy);
        tick();
        rst = 1'b1;
        tick();

        // Random traffic against a queue model; entries packed as {dump, pc, inst}
        model_q.delete();
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            d_ready = 1'($urandom_range(0, 1));
            flush   = ($urandom_range(0, 15) == 0);
            #1;
            check("rnd_f_ready", {31'b0, f_ready}, {31'b0, (model_q.size() < 2)});
            check("rnd_occ", {30'b0, occupancy}, 32'(model_q.size()));
            if (model_q.size() > 0) begin
                head = model_q[0];
                check("rnd_inst", {16'b0, d_inst}, {16'b0, head[15:0]});
                check("rnd_pc", {16'b0, d_pc_inc}, {16'b0, head[31:16]});
                check("rnd_dump", {31'b0, d_createdump}, {31'b0, head[32]});
            end else begin
                check("rnd_nop", {16'b0, d_inst}, 32'h0800);
            end
            m_push = f_valid && (model_q.size() < 2) && !flush;
            m_pop  = (model_q.size() > 0) && d_ready && !flush;
            if (c % 500 == 0) begin
                $display("txn rnd %0d: occ=%0d d_inst=%h", c, occupancy, d_inst);
            end
            @(posedge clk);
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_pop) void'(model_q.pop_front());
                if (m_push) model_q.push_back({f_createdump, f_pc_inc, f_inst});
            end
            #1;
        end
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
